// File: rtl/fma_feeder.sv
// fma_feeder: serialises an (a, b, c) operand triple onto the fma operand bus
// and hands the fma result, or a fault code, back over a valid/ready handshake.
module fma_feeder #(
    parameter int FP_WIDTH = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [FP_WIDTH-1:0] op_a,
    input  logic [FP_WIDTH-1:0] op_b,
    input  logic [FP_WIDTH-1:0] op_c,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [FP_WIDTH-1:0] res_data,
    output logic [1:0]          res_status,
    output logic                busy,
    output logic                fma_rst,
    output logic                fma_start,
    output logic [FP_WIDTH-1:0] fma_float_in,
    input  logic [FP_WIDTH-1:0] fma_float_out,
    input  logic                fma_ready,
    input  logic                fma_error
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       ST_OK    = 2'b00;
    localparam logic [1:0]       ST_ERR   = 2'b01;
    localparam logic [1:0]       ST_TMO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_SEND_C,
        S_WAIT,
        S_FLUSH,
        S_RESULT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [FP_WIDTH-1:0] r_a;
    logic [FP_WIDTH-1:0] r_b;
    logic [FP_WIDTH-1:0] r_c;
    logic [FP_WIDTH-1:0] r_res_data;
    logic [1:0]          r_res_status;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_timeout;

    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (op_valid) w_next = S_SEND_A;
            S_SEND_A: w_next = S_SEND_B;
            S_SEND_B: w_next = S_SEND_C;
            S_SEND_C: w_next = S_WAIT;
            S_WAIT: begin
                if (fma_ready || fma_error) begin
                    w_next = S_RESULT;
                end else if (w_timeout) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH:  w_next = S_RESULT;
            S_RESULT: if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // fma-facing outputs decode only from state and the latched operands.
    always_comb begin
        op_ready     = (r_state == S_IDLE);
        busy         = (r_state != S_IDLE);
        res_valid    = (r_state == S_RESULT);
        res_data     = r_res_data;
        res_status   = r_res_status;
        fma_start    = (r_state == S_SEND_A);
        fma_rst      = !rst || (r_state == S_FLUSH);
        fma_float_in = '0;
        case (r_state)
            S_SEND_A: fma_float_in = r_a;
            S_SEND_B: fma_float_in = r_b;
            S_SEND_C: fma_float_in = r_c;
            default:  fma_float_in = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_res_data   <= '0;
            r_res_status <= ST_OK;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_a <= op_a;
                        r_b <= op_b;
                        r_c <= op_c;
                    end
                end
                S_SEND_C: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (fma_ready) begin
                        r_res_data   <= fma_float_out;
                        r_res_status <= ST_OK;
                    end else if (fma_error) begin
                        r_res_data   <= '1;
                        r_res_status <= ST_ERR;
                    end else if (w_timeout) begin
                        r_res_data   <= '1;
                        r_res_status <= ST_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_feeder.sv
// tb_fma_feeder: drives random operand triples and fma behaviours into fma_feeder
// and compares every cycle against a timeline model of the protocol.
module tb_fma_feeder;

    localparam int          W        = 32;
    localparam int          TMO      = 16;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam int          M_READY  = 0;
    localparam int          M_ERROR  = 1;
    localparam int          M_BOTH   = 2;
    localparam int          M_NONE   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] op_c = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic [1:0]   res_status;
    logic         busy;
    logic         fma_rst;
    logic         fma_start;
    logic [W-1:0] fma_float_in;
    logic [W-1:0] fma_float_out = '0;
    logic         fma_ready = 1'b0;
    logic         fma_error = 1'b0;

    fma_feeder #(.FP_WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_c         (op_c),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_status   (res_status),
        .busy         (busy),
        .fma_rst      (fma_rst),
        .fma_start    (fma_start),
        .fma_float_in (fma_float_in),
        .fma_float_out(fma_float_out),
        .fma_ready    (fma_ready),
        .fma_error    (fma_error)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    // Stimulus-side controls (written by main only)
    int opK = 5;
    int opMode = M_READY;
    int rrCtl = 1;

    // Model state (written by the compare process only)
    bit          mBusy = 1'b0;
    int          age = 0;
    int          mResAge = 0;
    int          mFlushAge = 0;
    int          mK = 0;
    int          mMode = 0;
    logic [31:0] mA, mB, mC, mExpData;
    logic [1:0]  mExpStatus;
    int          mAcceptCyc = 0;
    int          mHsCyc = -100;
    int          mAcceptGap = 0;
    int          pendK = 0;
    int          pendMode = 0;
    int          firstRvCyc = 0;
    int          lastFlushCyc = 0;
    int          flushCount = 0;
    int          resultsSeen = 0;
    logic [31:0] lastData = '0;
    logic [31:0] seenData = '0;
    logic [1:0]  lastStatus = '0;
    logic [1:0]  seenStatus = '0;
    bit          prevRv = 1'b0;
    bit          expRv;

    // fma stub state (written by the fma process only)
    int          fState = 0;
    int          fW = 0;
    int          fK = 0;
    int          fMode = 0;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;
    logic [31:0] cc = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the fma arithmetic; the known single-precision case is exact.
    function automatic logic [31:0] fmaFn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == 32'h3FE0_0000 && b == 32'h3FC0_0000 && c == 32'h3F80_0000) begin
            return 32'h4068_0000;
        end
        return a * b + c;
    endfunction

    // Behavioural fma: collects a/b/c from the bus, then answers in WAIT cycle k.
    initial begin
        forever begin
            @(negedge clk);
            fma_ready     = 1'b0;
            fma_error     = 1'b0;
            fma_float_out = $urandom;
            if (!rst) begin
                fState = 0;
            end else begin
                case (fState)
                    0: begin
                        if (fma_start) begin
                            ca     = fma_float_in;
                            fK     = pendK;
                            fMode  = pendMode;
                            fState = 1;
                        end else if (op_ready && $urandom_range(7) == 0) begin
                            if ($urandom_range(1) == 1) fma_ready = 1'b1;
                            else                        fma_error = 1'b1;
                        end
                    end
                    1: begin
                        cb     = fma_float_in;
                        fState = 2;
                    end
                    2: begin
                        cc     = fma_float_in;
                        fW     = 0;
                        fState = 3;
                    end
                    default: begin
                        fW++;
                        if (fMode != M_NONE && fW == fK) begin
                            fma_ready = (fMode == M_READY || fMode == M_BOTH);
                            fma_error = (fMode == M_ERROR || fMode == M_BOTH);
                            if (fma_ready) fma_float_out = fmaFn(ca, cb, cc);
                            fState = 0;
                        end else if (fma_rst || fW > 40) begin
                            fState = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rrCtl == 1)      res_ready = 1'b1;
            else if (rrCtl == 2) res_ready = 1'b0;
            else                 res_ready = ($urandom_range(1) == 1);
        end
    end

    // Timeline model: an accepted op occupies ages 1..3 on the bus, its result
    // appears at age 4+k, or a flush at age 4+TIMEOUT when the fma stays silent.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!rst) begin
                mBusy  = 1'b0;
                prevRv = 1'b0;
                checkOutput("rst_op_ready", op_ready, 1);
                checkOutput("rst_res_valid", res_valid, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_fma_start", fma_start, 0);
                checkOutput("rst_bus", fma_float_in, 0);
                checkOutput("rst_fma_rst", fma_rst, 1);
                checkOutput("rst_res_data", res_data, 0);
                checkOutput("rst_res_status", res_status, 0);
                continue;
            end
            if (!mBusy) begin
                if (op_valid) begin
                    mBusy      = 1'b1;
                    age        = 1;
                    mA         = op_a;
                    mB         = op_b;
                    mC         = op_c;
                    mK         = opK;
                    mMode      = opMode;
                    pendK      = opK;
                    pendMode   = opMode;
                    mAcceptGap = cyc - mHsCyc;
                    mAcceptCyc = cyc;
                    if (mMode == M_NONE) begin
                        mFlushAge  = 4 + TMO;
                        mResAge    = 5 + TMO;
                        mExpData   = ALL_ONES;
                        mExpStatus = 2'b10;
                    end else begin
                        mFlushAge  = 0;
                        mResAge    = 4 + mK;
                        mExpData   = (mMode == M_ERROR) ? ALL_ONES : fmaFn(mA, mB, mC);
                        mExpStatus = (mMode == M_ERROR) ? 2'b01 : 2'b00;
                    end
                end
            end else if (age >= mResAge && res_ready) begin
                mBusy      = 1'b0;
                mHsCyc     = cyc;
                lastData   = seenData;
                lastStatus = seenStatus;
                resultsSeen++;
            end else begin
                age++;
            end

            expRv = mBusy && age >= mResAge;
            checkOutput("op_ready", op_ready, !mBusy);
            checkOutput("busy", busy, mBusy);
            checkOutput("fma_start", fma_start, mBusy && age == 1);
            checkOutput("fma_rst", fma_rst, mBusy && age == mFlushAge);
            checkOutput("res_valid", res_valid, expRv);
            if (mBusy && age <= 3) begin
                checkOutput("bus_operand", fma_float_in, (age == 1) ? mA : (age == 2) ? mB : mC);
            end else if (mBusy && age < ((mFlushAge != 0) ? mFlushAge : mResAge)) begin
                checkOutput("bus_wait", fma_float_in, 0);
            end
            if (expRv) begin
                checkOutput("res_data", res_data, mExpData);
                checkOutput("res_status", res_status, mExpStatus);
                seenData   = res_data;
                seenStatus = res_status;
            end
            if (fma_rst) begin
                flushCount++;
                lastFlushCyc = cyc;
            end
            if (res_valid && !prevRv) firstRvCyc = cyc;
            prevRv = res_valid;
        end
    end

    // Called on a falling edge; returns on the falling edge of the SEND_A cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input int k, input int mode);
        int n;
        n        = 0;
        opK      = k;
        opMode   = mode;
        op_valid = 1'b1;
        while (!op_ready && n < 400) begin
            op_a = $urandom;
            op_b = $urandom;
            op_c = $urandom;
            @(negedge clk);
            n++;
        end
        op_a = a;
        op_b = b;
        op_c = c;
        checkOutput("accept_ready", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (mBusy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", mBusy, 0);
    endtask

    initial begin
        int f0;
        int r0;
        int n;
        int rm;
        int k;
        int mode;

        #12;
        checkOutput("t0_op_ready", op_ready, 1);
        checkOutput("t0_res_valid", res_valid, 0);
        checkOutput("t0_busy", busy, 0);
        checkOutput("t0_fma_start", fma_start, 0);
        checkOutput("t0_bus", fma_float_in, 0);
        checkOutput("t0_fma_rst", fma_rst, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: nominal op
        f0 = flushCount;
        applyStimulus(32'h3FE0_0000, 32'h3FC0_0000, 32'h3F80_0000, 5, M_READY);
        waitIdle();
        checkOutput("t1_bus_a", ca, 32'h3FE0_0000);
        checkOutput("t1_bus_b", cb, 32'h3FC0_0000);
        checkOutput("t1_bus_c", cc, 32'h3F80_0000);
        checkOutput("t1_data", lastData, 32'h4068_0000);
        checkOutput("t1_status", lastStatus, 2'b00);
        checkOutput("t1_latency", firstRvCyc - mAcceptCyc, 8);
        checkOutput("t1_no_flush", flushCount - f0, 0);

        // Test 2: held result with a second op waiting
        rrCtl = 2;
        applyStimulus(32'h3FE0_0000, 32'h3FC0_0000, 32'h3F80_0000, 5, M_READY);
        op_a     = 32'd3;
        op_b     = 32'd5;
        op_c     = 32'd7;
        opK      = 3;
        opMode   = M_READY;
        op_valid = 1'b1;
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_result_appears", res_valid, 1);
        repeat (10) @(negedge clk);
        checkOutput("t2_held_valid", res_valid, 1);
        checkOutput("t2_held_data", res_data, 32'h4068_0000);
        checkOutput("t2_op_ready_low", op_ready, 0);
        rrCtl = 1;
        n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_release", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("t2_accept_gap", mAcceptGap, 1);
        checkOutput("t2_first_data", lastData, 32'h4068_0000);
        waitIdle();
        checkOutput("t2_second_data", lastData, 32'd22);

        // Test 3: fma never answers
        f0 = flushCount;
        applyStimulus(32'd1, 32'd2, 32'd3, 1, M_NONE);
        waitIdle();
        checkOutput("t3_data", lastData, ALL_ONES);
        checkOutput("t3_status", lastStatus, 2'b10);
        checkOutput("t3_flush_pulses", flushCount - f0, 1);
        checkOutput("t3_flush_time", lastFlushCyc - mAcceptCyc, 19);
        checkOutput("t3_result_time", firstRvCyc - mAcceptCyc, 20);

        // Test 4: error in the 2nd WAIT cycle
        f0 = flushCount;
        applyStimulus(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 2, M_ERROR);
        waitIdle();
        checkOutput("t4_data", lastData, ALL_ONES);
        checkOutput("t4_status", lastStatus, 2'b01);
        checkOutput("t4_no_flush", flushCount - f0, 0);
        checkOutput("t4_latency", firstRvCyc - mAcceptCyc, 5);

        // Test 5: ready and error together
        applyStimulus(32'h3FE0_0000, 32'h3FC0_0000, 32'h3F80_0000, 3, M_BOTH);
        waitIdle();
        checkOutput("t5_data", lastData, 32'h4068_0000);
        checkOutput("t5_status", lastStatus, 2'b00);
        checkOutput("t5_latency", firstRvCyc - mAcceptCyc, 6);

        // Randomised traffic with backpressure and spurious fma pulses
        rrCtl = 0;
        r0 = resultsSeen;
        for (int i = 0; i < 50; i++) begin
            rm = $urandom_range(15);
            if (rm < 10)      mode = M_READY;
            else if (rm < 12) mode = M_ERROR;
            else if (rm < 14) mode = M_BOTH;
            else              mode = M_NONE;
            k = $urandom_range(TMO, 1);
            applyStimulus($urandom, $urandom, $urandom, k, mode);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        waitIdle();
        checkOutput("random_all_results", resultsSeen - r0, 50);
        rrCtl = 1;

        // Test 6: reset in SEND_B
        r0 = resultsSeen;
        applyStimulus(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 4, M_READY);
        @(posedge clk);
        #3;
        checkOutput("t6_in_send_b", fma_float_in, 32'hBBBB_0002);
        rst = 1'b0;
        #1;
        checkOutput("t6_op_ready", op_ready, 1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_res_valid", res_valid, 0);
        checkOutput("t6_fma_start", fma_start, 0);
        checkOutput("t6_bus", fma_float_in, 0);
        checkOutput("t6_fma_rst", fma_rst, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("t6_idle_after", op_ready, 1);
        checkOutput("t6_no_result", resultsSeen - r0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: actual still running, required finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
